// File: rtl/uncore_ahb_arbiter_pkg.sv
// Shared types and AHB-Lite encodings for the two-manager uncore arbiter.
// The configuration struct carries only the widths that the arbiter reads.
package uncore_ahb_arbiter_pkg;

    typedef struct packed {
        int unsigned PA_BITS;
        int unsigned AHBW;
        int unsigned XLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{PA_BITS: 32, AHBW: 32, XLEN: 32};

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Beats still to follow the NONSEQ of a fixed-length burst.
    function automatic logic [3:0] burst_remaining(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_remaining = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  burst_remaining = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: burst_remaining = 4'd15;
            default:                      burst_remaining = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/uncore_ahb_arbiter_capture.sv
// Address-phase capture for one manager: holds a NONSEQ that lost arbitration
// and presents it (or the live request when empty) as that manager's source.
module ahbreqcapture #(
    parameter int unsigned PA_BITS = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               clear,
    input  logic [PA_BITS-1:0] live_haddr,
    input  logic               live_hwrite,
    input  logic [2:0]         live_hsize,
    input  logic [2:0]         live_hburst,
    input  logic [1:0]         live_htrans,
    input  logic               live_hmastlock,
    output logic               valid,
    output logic [PA_BITS-1:0] src_haddr,
    output logic               src_hwrite,
    output logic [2:0]         src_hsize,
    output logic [2:0]         src_hburst,
    output logic [1:0]         src_htrans,
    output logic               src_hmastlock
);

    logic [PA_BITS-1:0] cap_haddr;
    logic               cap_hwrite;
    logic [2:0]         cap_hsize;
    logic [2:0]         cap_hburst;
    logic [1:0]         cap_htrans;
    logic               cap_hmastlock;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid         <= 1'b0;
            cap_haddr     <= '0;
            cap_hwrite    <= 1'b0;
            cap_hsize     <= '0;
            cap_hburst    <= '0;
            cap_htrans    <= '0;
            cap_hmastlock <= 1'b0;
        end else if (load) begin
            valid         <= 1'b1;
            cap_haddr     <= live_haddr;
            cap_hwrite    <= live_hwrite;
            cap_hsize     <= live_hsize;
            cap_hburst    <= live_hburst;
            cap_htrans    <= live_htrans;
            cap_hmastlock <= live_hmastlock;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    always_comb begin
        src_haddr     = valid ? cap_haddr     : live_haddr;
        src_hwrite    = valid ? cap_hwrite    : live_hwrite;
        src_hsize     = valid ? cap_hsize     : live_hsize;
        src_hburst    = valid ? cap_hburst    : live_hburst;
        src_htrans    = valid ? cap_htrans    : live_htrans;
        src_hmastlock = valid ? cap_hmastlock : live_hmastlock;
    end

endmodule

// File: rtl/uncore_ahb_arbiter.sv
// Round-robin AHB-Lite arbiter sharing the uncore port between the BIU (M0)
// and DMA (M1); ownership changes only at burst boundaries outside locks.
module uncore_ahb_arbiter
    import uncore_ahb_arbiter_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [P.PA_BITS-1:0]   M0HADDR,
    input  logic [P.PA_BITS-1:0]   M1HADDR,
    input  logic [P.AHBW-1:0]      M0HWDATA,
    input  logic [P.AHBW-1:0]      M1HWDATA,
    input  logic [P.XLEN/8-1:0]    M0HWSTRB,
    input  logic [P.XLEN/8-1:0]    M1HWSTRB,
    input  logic                   M0HWRITE,
    input  logic                   M1HWRITE,
    input  logic [2:0]             M0HSIZE,
    input  logic [2:0]             M1HSIZE,
    input  logic [2:0]             M0HBURST,
    input  logic [2:0]             M1HBURST,
    input  logic [1:0]             M0HTRANS,
    input  logic [1:0]             M1HTRANS,
    input  logic                   M0HMASTLOCK,
    input  logic                   M1HMASTLOCK,
    output logic                   M0HREADY,
    output logic                   M1HREADY,
    output logic [P.AHBW-1:0]      M0HRDATA,
    output logic [P.AHBW-1:0]      M1HRDATA,
    output logic                   M0HRESP,
    output logic                   M1HRESP,
    output logic [P.PA_BITS-1:0]   HADDR,
    output logic [P.AHBW-1:0]      HWDATA,
    output logic [P.XLEN/8-1:0]    HWSTRB,
    output logic                   HWRITE,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic [1:0]             HTRANS,
    output logic                   HMASTLOCK,
    input  logic                   HREADY,
    input  logic [P.AHBW-1:0]      HRDATA,
    input  logic                   HRESP
);

    arb_state_t state, addr_owner, data_owner;
    logic       lastgrant;
    logic [3:0] beatcnt;
    logic       req0, req1, owner_lock, boundary, tie;
    logic       cap0_valid, cap1_valid, load0, load1, clear0, clear1;

    logic [P.PA_BITS-1:0] s0_haddr, s1_haddr;
    logic                 s0_hwrite, s1_hwrite, s0_hmastlock, s1_hmastlock;
    logic [2:0]           s0_hsize, s1_hsize, s0_hburst, s1_hburst;
    logic [1:0]           s0_htrans, s1_htrans;

    // A manager whose NONSEQ is not issued this cycle still sees it accepted
    // (its HREADY is high), so it must be captured for later replay.
    assign load0  = (M0HTRANS == HTRANS_NONSEQ) && (addr_owner != ARB_OWN0) && M0HREADY;
    assign load1  = (M1HTRANS == HTRANS_NONSEQ) && (addr_owner != ARB_OWN1) && M1HREADY;
    assign clear0 = (addr_owner == ARB_OWN0) && cap0_valid && HREADY;
    assign clear1 = (addr_owner == ARB_OWN1) && cap1_valid && HREADY;

    ahbreqcapture #(.PA_BITS(P.PA_BITS)) u_cap0 (
        .clk(HCLK), .resetn(HRESETn), .load(load0), .clear(clear0),
        .live_haddr(M0HADDR), .live_hwrite(M0HWRITE), .live_hsize(M0HSIZE),
        .live_hburst(M0HBURST), .live_htrans(M0HTRANS), .live_hmastlock(M0HMASTLOCK),
        .valid(cap0_valid),
        .src_haddr(s0_haddr), .src_hwrite(s0_hwrite), .src_hsize(s0_hsize),
        .src_hburst(s0_hburst), .src_htrans(s0_htrans), .src_hmastlock(s0_hmastlock)
    );

    ahbreqcapture #(.PA_BITS(P.PA_BITS)) u_cap1 (
        .clk(HCLK), .resetn(HRESETn), .load(load1), .clear(clear1),
        .live_haddr(M1HADDR), .live_hwrite(M1HWRITE), .live_hsize(M1HSIZE),
        .live_hburst(M1HBURST), .live_htrans(M1HTRANS), .live_hmastlock(M1HMASTLOCK),
        .valid(cap1_valid),
        .src_haddr(s1_haddr), .src_hwrite(s1_hwrite), .src_hsize(s1_hsize),
        .src_hburst(s1_hburst), .src_htrans(s1_htrans), .src_hmastlock(s1_hmastlock)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state <= ARB_IDLE;
        else          state <= addr_owner;
    end

    // addr_owner is the granted owner for this cycle; a boundary decision
    // takes effect immediately so an uncontended request has no added latency.
    always_comb begin
        addr_owner = state;
        tie        = 1'b0;
        req0       = (s0_htrans == HTRANS_NONSEQ);
        req1       = (s1_htrans == HTRANS_NONSEQ);
        case (state)
            ARB_OWN0: owner_lock = s0_hmastlock;
            ARB_OWN1: owner_lock = s1_hmastlock;
            default:  owner_lock = 1'b0;
        endcase
        boundary = HREADY && ((state == ARB_IDLE) || ((beatcnt == 4'd0) && !owner_lock));
        if (boundary) begin
            if (req0 && req1) begin
                tie        = 1'b1;
                addr_owner = lastgrant ? ARB_OWN0 : ARB_OWN1;
            end else if (req0) begin
                addr_owner = ARB_OWN0;
            end else if (req1) begin
                addr_owner = ARB_OWN1;
            end else begin
                addr_owner = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            data_owner <= ARB_IDLE;
            lastgrant  <= 1'b1;
            beatcnt    <= '0;
        end else begin
            if (tie) lastgrant <= (addr_owner == ARB_OWN1);
            if (HREADY) begin
                data_owner <= (HTRANS != HTRANS_IDLE) ? addr_owner : ARB_IDLE;
                if (HRESP)
                    beatcnt <= '0;
                else if (HTRANS == HTRANS_NONSEQ)
                    beatcnt <= burst_remaining(HBURST);
                else if ((HTRANS == HTRANS_SEQ) && (beatcnt != 4'd0))
                    beatcnt <= beatcnt - 4'd1;
            end
        end
    end

    always_comb begin
        HADDR     = '0;
        HWRITE    = 1'b0;
        HSIZE     = '0;
        HBURST    = '0;
        HTRANS    = HTRANS_IDLE;
        HMASTLOCK = 1'b0;
        case (addr_owner)
            ARB_OWN0: begin
                HADDR = s0_haddr; HWRITE = s0_hwrite; HSIZE = s0_hsize;
                HBURST = s0_hburst; HTRANS = s0_htrans; HMASTLOCK = s0_hmastlock;
            end
            ARB_OWN1: begin
                HADDR = s1_haddr; HWRITE = s1_hwrite; HSIZE = s1_hsize;
                HBURST = s1_hburst; HTRANS = s1_htrans; HMASTLOCK = s1_hmastlock;
            end
            default: ;
        endcase
    end

    always_comb begin
        HWDATA = '0;
        HWSTRB = '0;
        case (data_owner)
            ARB_OWN0: begin HWDATA = M0HWDATA; HWSTRB = M0HWSTRB; end
            ARB_OWN1: begin HWDATA = M1HWDATA; HWSTRB = M1HWSTRB; end
            default: ;
        endcase
    end

    assign M0HREADY = (data_owner == ARB_OWN0) ? HREADY : !cap0_valid;
    assign M1HREADY = (data_owner == ARB_OWN1) ? HREADY : !cap1_valid;
    assign M0HRDATA = (data_owner == ARB_OWN0) ? HRDATA : '0;
    assign M1HRDATA = (data_owner == ARB_OWN1) ? HRDATA : '0;
    assign M0HRESP  = (data_owner == ARB_OWN0) && HRESP;
    assign M1HRESP  = (data_owner == ARB_OWN1) && HRESP;

endmodule

// File: tb/tb_uncore_ahb_arbiter.sv
// Directed self-checking bench for uncore_ahb_arbiter: each task drives one
// scenario cycle by cycle and compares against hand-derived values.
module tb_uncore_ahb_arbiter;
    import uncore_ahb_arbiter_pkg::*;

    logic        HCLK, HRESETn;
    logic [31:0] M0HADDR, M1HADDR, M0HWDATA, M1HWDATA;
    logic [3:0]  M0HWSTRB, M1HWSTRB;
    logic        M0HWRITE, M1HWRITE, M0HMASTLOCK, M1HMASTLOCK;
    logic [2:0]  M0HSIZE, M1HSIZE, M0HBURST, M1HBURST;
    logic [1:0]  M0HTRANS, M1HTRANS;
    logic        M0HREADY, M1HREADY, M0HRESP, M1HRESP;
    logic [31:0] M0HRDATA, M1HRDATA;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [3:0]  HWSTRB;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;

    int tests = 0;
    int failed = 0;

    uncore_ahb_arbiter #(.P(CVW_DEFAULT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0HADDR(M0HADDR), .M1HADDR(M1HADDR), .M0HWDATA(M0HWDATA), .M1HWDATA(M1HWDATA),
        .M0HWSTRB(M0HWSTRB), .M1HWSTRB(M1HWSTRB), .M0HWRITE(M0HWRITE), .M1HWRITE(M1HWRITE),
        .M0HSIZE(M0HSIZE), .M1HSIZE(M1HSIZE), .M0HBURST(M0HBURST), .M1HBURST(M1HBURST),
        .M0HTRANS(M0HTRANS), .M1HTRANS(M1HTRANS), .M0HMASTLOCK(M0HMASTLOCK), .M1HMASTLOCK(M1HMASTLOCK),
        .M0HREADY(M0HREADY), .M1HREADY(M1HREADY), .M0HRDATA(M0HRDATA), .M1HRDATA(M1HRDATA),
        .M0HRESP(M0HRESP), .M1HRESP(M1HRESP),
        .HADDR(HADDR), .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step;
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive0(input logic [1:0] t, input logic [31:0] a, input logic [2:0] b,
                          input logic w, input logic lk);
        M0HTRANS = t; M0HADDR = a; M0HBURST = b; M0HWRITE = w; M0HMASTLOCK = lk; M0HSIZE = 3'd2;
    endtask

    task automatic drive1(input logic [1:0] t, input logic [31:0] a, input logic [2:0] b,
                          input logic w, input logic lk);
        M1HTRANS = t; M1HADDR = a; M1HBURST = b; M1HWRITE = w; M1HMASTLOCK = lk; M1HSIZE = 3'd2;
    endtask

    task automatic idle_both;
        drive0(HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1'b0, 1'b0);
        drive1(HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        M0HWDATA = '0; M1HWDATA = '0; M0HWSTRB = '0; M1HWSTRB = '0;
        idle_both();
        step(); step(); #2;
        tests++; if (HTRANS !== 2'b00) begin failed++; $display("FAIL reset_htrans got %b exp 00", HTRANS); end
        tests++; if (M0HREADY !== 1'b1) begin failed++; $display("FAIL reset_m0hready got %b exp 1", M0HREADY); end
        tests++; if (M1HREADY !== 1'b1) begin failed++; $display("FAIL reset_m1hready got %b exp 1", M1HREADY); end
        tests++; if (M0HRESP !== 1'b0) begin failed++; $display("FAIL reset_m0hresp got %b exp 0", M0HRESP); end
        tests++; if (M1HRESP !== 1'b0) begin failed++; $display("FAIL reset_m1hresp got %b exp 0", M1HRESP); end
        HRESETn = 1'b1;
        step();
    endtask

    task automatic test_single;
        drive0(HTRANS_NONSEQ, 32'h8000_0000, HBURST_SINGLE, 1'b0, 1'b0); #2;
        tests++; if (HTRANS !== HTRANS_NONSEQ) begin failed++; $display("FAIL single_htrans got %b exp 10", HTRANS); end
        tests++; if (HADDR !== 32'h8000_0000) begin failed++; $display("FAIL single_haddr got %h exp 80000000", HADDR); end
        step();
        idle_both(); HRDATA = 32'hDEAD_BEEF; #2;
        tests++; if (M0HRDATA !== 32'hDEAD_BEEF) begin failed++; $display("FAIL single_m0hrdata got %h exp deadbeef", M0HRDATA); end
        tests++; if (M1HRDATA !== 32'h0) begin failed++; $display("FAIL single_m1hrdata got %h exp 0", M1HRDATA); end
        tests++; if (M0HREADY !== 1'b1) begin failed++; $display("FAIL single_m0hready got %b exp 1", M0HREADY); end
        step();
        HRDATA = '0;
    endtask

    task automatic test_tie;
        logic [31:0] wa, la, wrd, lrd;
        logic        lrdy;
        for (int r = 0; r < 2; r++) begin
            wa = (r == 0) ? 32'h1000 : 32'h2000;
            la = (r == 0) ? 32'h2000 : 32'h1000;
            drive0(HTRANS_NONSEQ, 32'h1000, HBURST_SINGLE, 1'b0, 1'b0);
            drive1(HTRANS_NONSEQ, 32'h2000, HBURST_SINGLE, 1'b0, 1'b0); #2;
            lrdy = (r == 0) ? M1HREADY : M0HREADY;
            tests++; if (HADDR !== wa) begin failed++; $display("FAIL tie%0d_first_haddr got %h exp %h", r, HADDR, wa); end
            tests++; if (lrdy !== 1'b1) begin failed++; $display("FAIL tie%0d_loser_ready0 got %b exp 1", r, lrdy); end
            step();
            idle_both(); HRDATA = 32'h11; #2;
            lrdy = (r == 0) ? M1HREADY : M0HREADY;
            wrd  = (r == 0) ? M0HRDATA : M1HRDATA;
            tests++; if (HADDR !== la) begin failed++; $display("FAIL tie%0d_second_haddr got %h exp %h", r, HADDR, la); end
            tests++; if (HTRANS !== HTRANS_NONSEQ) begin failed++; $display("FAIL tie%0d_second_htrans got %b exp 10", r, HTRANS); end
            tests++; if (lrdy !== 1'b0) begin failed++; $display("FAIL tie%0d_loser_ready1 got %b exp 0", r, lrdy); end
            tests++; if (wrd !== 32'h11) begin failed++; $display("FAIL tie%0d_winner_rdata got %h exp 11", r, wrd); end
            step();
            HRDATA = 32'h22; #2;
            lrdy = (r == 0) ? M1HREADY : M0HREADY;
            lrd  = (r == 0) ? M1HRDATA : M0HRDATA;
            tests++; if (lrd !== 32'h22) begin failed++; $display("FAIL tie%0d_loser_rdata got %h exp 22", r, lrd); end
            tests++; if (lrdy !== 1'b1) begin failed++; $display("FAIL tie%0d_loser_ready2 got %b exp 1", r, lrdy); end
            tests++; if (HTRANS !== HTRANS_IDLE) begin failed++; $display("FAIL tie%0d_idle_after got %b exp 00", r, HTRANS); end
            step();
            HRDATA = '0;
        end
    endtask

    task automatic test_burst;
        logic [31:0] ea;
        drive0(HTRANS_NONSEQ, 32'h100, HBURST_INCR4, 1'b0, 1'b0); #2;
        tests++; if (HADDR !== 32'h100) begin failed++; $display("FAIL burst_beat0 got %h exp 100", HADDR); end
        step();
        for (int b = 1; b < 4; b++) begin
            ea = 32'h100 + 32'(b * 4);
            drive0(HTRANS_SEQ, ea, HBURST_INCR4, 1'b0, 1'b0);
            if (b == 1) drive1(HTRANS_NONSEQ, 32'h3000, HBURST_SINGLE, 1'b0, 1'b0);
            else        drive1(HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1'b0, 1'b0);
            #2;
            tests++; if (HADDR !== ea || HTRANS !== HTRANS_SEQ) begin failed++; $display("FAIL burst_beat%0d got %h/%b exp %h/11", b, HADDR, HTRANS, ea); end
            tests++; if (M1HREADY !== (b == 1)) begin failed++; $display("FAIL burst_m1hready%0d got %b exp %b", b, M1HREADY, (b == 1)); end
            step();
        end
        idle_both(); #2;
        tests++; if (HADDR !== 32'h3000 || HTRANS !== HTRANS_NONSEQ) begin failed++; $display("FAIL burst_handoff got %h/%b exp 3000/10", HADDR, HTRANS); end
        tests++; if (M1HREADY !== 1'b0) begin failed++; $display("FAIL burst_handoff_m1hready got %b exp 0", M1HREADY); end
        step(); #2;
        tests++; if (M1HREADY !== 1'b1) begin failed++; $display("FAIL burst_m1_data got %b exp 1", M1HREADY); end
        step();
    endtask

    task automatic test_lock;
        drive1(HTRANS_NONSEQ, 32'h4000, HBURST_SINGLE, 1'b0, 1'b1); #2;
        tests++; if (HADDR !== 32'h4000 || HMASTLOCK !== 1'b1) begin failed++; $display("FAIL lock_first got %h/%b exp 4000/1", HADDR, HMASTLOCK); end
        step();
        drive1(HTRANS_NONSEQ, 32'h4004, HBURST_SINGLE, 1'b0, 1'b1);
        drive0(HTRANS_NONSEQ, 32'h5000, HBURST_SINGLE, 1'b0, 1'b0); #2;
        tests++; if (HADDR !== 32'h4004) begin failed++; $display("FAIL lock_second got %h exp 4004", HADDR); end
        tests++; if (M0HREADY !== 1'b1) begin failed++; $display("FAIL lock_m0_capture got %b exp 1", M0HREADY); end
        step();
        drive1(HTRANS_NONSEQ, 32'h4008, HBURST_SINGLE, 1'b0, 1'b1);
        drive0(HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1'b0, 1'b0); #2;
        tests++; if (HADDR !== 32'h4008) begin failed++; $display("FAIL lock_third got %h exp 4008", HADDR); end
        tests++; if (M0HREADY !== 1'b0) begin failed++; $display("FAIL lock_m0_held got %b exp 0", M0HREADY); end
        step();
        drive1(HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1'b0, 1'b1); #2;
        tests++; if (HTRANS !== HTRANS_IDLE) begin failed++; $display("FAIL lock_idle_held got %b exp 00", HTRANS); end
        tests++; if (M0HREADY !== 1'b0) begin failed++; $display("FAIL lock_m0_still_held got %b exp 0", M0HREADY); end
        step();
        drive1(HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1'b0, 1'b0); #2;
        tests++; if (HADDR !== 32'h5000 || HTRANS !== HTRANS_NONSEQ) begin failed++; $display("FAIL lock_release got %h/%b exp 5000/10", HADDR, HTRANS); end
        tests++; if (HMASTLOCK !== 1'b0) begin failed++; $display("FAIL lock_release_lock got %b exp 0", HMASTLOCK); end
        step(); #2;
        tests++; if (M0HREADY !== 1'b1) begin failed++; $display("FAIL lock_m0_done got %b exp 1", M0HREADY); end
        step();
    endtask

    task automatic test_wait_states;
        drive0(HTRANS_NONSEQ, 32'h6000, HBURST_SINGLE, 1'b1, 1'b0);
        drive1(HTRANS_NONSEQ, 32'h7000, HBURST_SINGLE, 1'b1, 1'b0); #2;
        tests++; if (HADDR !== 32'h6000 || HWRITE !== 1'b1) begin failed++; $display("FAIL ws_first got %h/%b exp 6000/1", HADDR, HWRITE); end
        step();
        idle_both();
        M0HWDATA = 32'hA0A0_A0A0; M0HWSTRB = 4'hF;
        M1HWDATA = 32'hB1B1_B1B1; M1HWSTRB = 4'h3;
        for (int w = 0; w < 2; w++) begin
            HREADY = 1'b0; #2;
            tests++; if (HWDATA !== 32'hA0A0_A0A0 || HWSTRB !== 4'hF) begin failed++; $display("FAIL ws%0d_hwdata got %h/%h exp a0a0a0a0/f", w, HWDATA, HWSTRB); end
            tests++; if (HTRANS !== HTRANS_IDLE) begin failed++; $display("FAIL ws%0d_htrans got %b exp 00", w, HTRANS); end
            tests++; if (M0HREADY !== 1'b0 || M1HREADY !== 1'b0) begin failed++; $display("FAIL ws%0d_ready got %b%b exp 00", w, M0HREADY, M1HREADY); end
            step();
        end
        HREADY = 1'b1; #2;
        tests++; if (HADDR !== 32'h7000 || HTRANS !== HTRANS_NONSEQ || HWRITE !== 1'b1) begin failed++; $display("FAIL ws_replay got %h/%b/%b exp 7000/10/1", HADDR, HTRANS, HWRITE); end
        tests++; if (HWDATA !== 32'hA0A0_A0A0) begin failed++; $display("FAIL ws_m0_data_done got %h exp a0a0a0a0", HWDATA); end
        tests++; if (M0HREADY !== 1'b1 || M1HREADY !== 1'b0) begin failed++; $display("FAIL ws_replay_ready got %b%b exp 10", M0HREADY, M1HREADY); end
        step(); #2;
        tests++; if (HWDATA !== 32'hB1B1_B1B1 || HWSTRB !== 4'h3) begin failed++; $display("FAIL ws_m1_data got %h/%h exp b1b1b1b1/3", HWDATA, HWSTRB); end
        tests++; if (M1HREADY !== 1'b1) begin failed++; $display("FAIL ws_m1_ready got %b exp 1", M1HREADY); end
        tests++; if (HTRANS !== HTRANS_IDLE) begin failed++; $display("FAIL ws_no_dup got %b exp 00", HTRANS); end
        step(); #2;
        tests++; if (HTRANS !== HTRANS_IDLE || M1HREADY !== 1'b1) begin failed++; $display("FAIL ws_quiet got %b/%b exp 00/1", HTRANS, M1HREADY); end
        step();
        M0HWDATA = '0; M1HWDATA = '0; M0HWSTRB = '0; M1HWSTRB = '0;
    endtask

    task automatic test_error;
        drive0(HTRANS_NONSEQ, 32'h200, HBURST_INCR8, 1'b0, 1'b0); #2;
        tests++; if (HADDR !== 32'h200) begin failed++; $display("FAIL err_beat0 got %h exp 200", HADDR); end
        step();
        drive0(HTRANS_SEQ, 32'h204, HBURST_INCR8, 1'b0, 1'b0);
        drive1(HTRANS_NONSEQ, 32'h9000, HBURST_SINGLE, 1'b0, 1'b0); #2;
        tests++; if (HADDR !== 32'h204) begin failed++; $display("FAIL err_beat1 got %h exp 204", HADDR); end
        step();
        drive0(HTRANS_SEQ, 32'h208, HBURST_INCR8, 1'b0, 1'b0);
        drive1(HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1'b0, 1'b0); step();
        drive0(HTRANS_SEQ, 32'h20C, HBURST_INCR8, 1'b0, 1'b0);
        HREADY = 1'b0; HRESP = 1'b1; #2;
        tests++; if (M0HRESP !== 1'b1 || M0HREADY !== 1'b0) begin failed++; $display("FAIL err_cycle1 got %b/%b exp 1/0", M0HRESP, M0HREADY); end
        tests++; if (M1HRESP !== 1'b0) begin failed++; $display("FAIL err_m1hresp got %b exp 0", M1HRESP); end
        step();
        idle_both(); HREADY = 1'b1; #2;
        tests++; if (M0HRESP !== 1'b1 || M0HREADY !== 1'b1) begin failed++; $display("FAIL err_cycle2 got %b/%b exp 1/1", M0HRESP, M0HREADY); end
        tests++; if (HTRANS !== HTRANS_IDLE) begin failed++; $display("FAIL err_abort_idle got %b exp 00", HTRANS); end
        step();
        HRESP = 1'b0; #2;
        tests++; if (HADDR !== 32'h9000 || HTRANS !== HTRANS_NONSEQ) begin failed++; $display("FAIL err_m1_grant got %h/%b exp 9000/10", HADDR, HTRANS); end
        tests++; if (M1HREADY !== 1'b0) begin failed++; $display("FAIL err_m1_wait got %b exp 0", M1HREADY); end
        step(); #2;
        tests++; if (M1HREADY !== 1'b1 || HTRANS !== HTRANS_IDLE) begin failed++; $display("FAIL err_m1_done got %b/%b exp 1/00", M1HREADY, HTRANS); end
        step();
    endtask

    task automatic test_reset_midburst;
        drive0(HTRANS_NONSEQ, 32'h300, HBURST_INCR4, 1'b0, 1'b0); step();
        drive0(HTRANS_SEQ, 32'h304, HBURST_INCR4, 1'b0, 1'b0);
        drive1(HTRANS_NONSEQ, 32'h3300, HBURST_SINGLE, 1'b0, 1'b0); step();
        idle_both(); HRESETn = 1'b0; step();
        HRESETn = 1'b1; #2;
        tests++; if (HTRANS !== HTRANS_IDLE) begin failed++; $display("FAIL rst_mid_htrans got %b exp 00", HTRANS); end
        tests++; if (M0HREADY !== 1'b1 || M1HREADY !== 1'b1) begin failed++; $display("FAIL rst_mid_ready got %b%b exp 11", M0HREADY, M1HREADY); end
        step();
        drive0(HTRANS_NONSEQ, 32'h400, HBURST_SINGLE, 1'b0, 1'b0);
        drive1(HTRANS_NONSEQ, 32'h4400, HBURST_SINGLE, 1'b0, 1'b0); #2;
        tests++; if (HADDR !== 32'h400) begin failed++; $display("FAIL rst_mid_tie got %h exp 400", HADDR); end
        step();
        idle_both(); #2;
        tests++; if (HADDR !== 32'h4400 || M1HREADY !== 1'b0) begin failed++; $display("FAIL rst_mid_replay got %h/%b exp 4400/0", HADDR, M1HREADY); end
        step(); #2;
        tests++; if (HTRANS !== HTRANS_IDLE) begin failed++; $display("FAIL rst_mid_end got %b exp 00", HTRANS); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_burst();
        test_lock();
        test_wait_states();
        test_error();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
